// File: rtl/fnd_digit_scanner.sv
// Time-multiplexed FND digit scanner: prescaled slot counter, masked digit skip,
// blank window and polarity select. Define FND_DIMMING_EN to add i_bright dimming.
`timescale 1ns/1ps

module fnd_digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SEL_W        = $clog2(NUM_DIGITS),
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [NUM_DIGITS-1:0] i_digitMask,
`ifdef FND_DIMMING_EN
    input  logic [3:0]            i_bright,
`endif
    output logic [SEL_W-1:0]      o_fndSel,
    output logic [NUM_DIGITS-1:0] o_fndSelect,
    output logic                  o_blank,
    output logic                  o_scanTick
);

    localparam int                    CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] INACTIVE = {NUM_DIGITS{ACTIVE_LOW}};

    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_fndSelect;
    logic                  r_blank;
    logic                  r_scanTick;

    logic                  w_terminal;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [SEL_W-1:0]      w_idx_next;
    logic                  w_past_blank;
    logic                  w_dim_ok;
    logic                  w_active;
    logic [NUM_DIGITS-1:0] w_onehot;

    // First enabled digit after cur, wrapping; keeps cur if no other digit is enabled.
    function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0]      cur,
                                                    input logic [NUM_DIGITS-1:0] mask);
        logic [SEL_W-1:0] result;
        logic [SEL_W-1:0] cand_idx;
        logic             found;
        int               cand;
        result = cur;
        found  = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            cand = int'(cur) + k;
            if (cand >= NUM_DIGITS) cand = cand - NUM_DIGITS;
            cand_idx = SEL_W'(cand);
            if (!found && mask[cand_idx]) begin
                result = cand_idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign w_terminal = (r_cnt == LAST_CNT);

    always_comb begin
        w_cnt_next = r_cnt;
        w_idx_next = r_idx;
        if (i_enable) begin
            if (w_terminal) begin
                w_cnt_next = '0;
                w_idx_next = next_index(r_idx, i_digitMask);
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_past_blank = 1'b1;
        end else begin : g_blank
            assign w_past_blank = (w_cnt_next >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef FND_DIMMING_EN
    localparam int STEP = (SCAN_DIV - BLANK_CYCLES) / 16;

    logic [3:0] r_bright;
    logic [3:0] w_bright;

    // Brightness is captured only around the slot boundary, so a change lands on the next slot.
    assign w_bright = (r_cnt == '0 || w_cnt_next == '0) ? i_bright : r_bright;
    assign w_dim_ok = (w_bright == 4'hF) ||
                      ((32'(w_cnt_next) - 32'(BLANK_CYCLES)) < (32'(w_bright) * 32'(STEP)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_bright <= '0;
        else         r_bright <= w_bright;
    end
`else
    assign w_dim_ok = 1'b1;
`endif

    assign w_active = i_enable && w_past_blank && i_digitMask[w_idx_next] && w_dim_ok;
    assign w_onehot = w_active ? (NUM_DIGITS'(1) << w_idx_next) : '0;

    // NOTE: outputs are registered from next-state values so no input reaches a select pin
    // through logic; all state uses non-blocking assignments and clears on async reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_fndSelect <= INACTIVE;
            r_blank     <= 1'b1;
            r_scanTick  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_fndSelect <= w_onehot ^ INACTIVE;
            r_blank     <= !w_active;
            r_scanTick  <= i_enable && (w_cnt_next == LAST_CNT);
        end
    end

    assign o_fndSel    = r_idx;
    assign o_fndSelect = r_fndSelect;
    assign o_blank     = r_blank;
    assign o_scanTick  = r_scanTick;

endmodule

// File: tb/tb_fnd_digit_scanner.sv
// Scoreboard bench for fnd_digit_scanner: three parameterisations share one clock,
// stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_fnd_digit_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_no = 0;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    // A: 4 digits, SCAN_DIV=4, BLANK=1, active high
    logic       rst_a, en_a, blank_a, tick_a;
    logic [3:0] mask_a, select_a;
    logic [1:0] sel_a;
    // B: 4 digits, SCAN_DIV=36, BLANK=4, active low
    logic       rst_b, en_b, blank_b, tick_b;
    logic [3:0] mask_b, select_b;
    logic [1:0] sel_b;
    // C: 3 digits, SCAN_DIV=2, BLANK=0, active high
    logic       rst_c, en_c, blank_c, tick_c;
    logic [2:0] mask_c, select_c;
    logic [1:0] sel_c;
`ifdef FND_DIMMING_EN
    logic [3:0] bright_b;
`endif

    fnd_digit_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_enable(en_a), .i_digitMask(mask_a),
`ifdef FND_DIMMING_EN
        .i_bright(4'hF),
`endif
        .o_fndSel(sel_a), .o_fndSelect(select_a), .o_blank(blank_a), .o_scanTick(tick_a)
    );

    fnd_digit_scanner #(.NUM_DIGITS(4), .SCAN_DIV(36), .BLANK_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_enable(en_b), .i_digitMask(mask_b),
`ifdef FND_DIMMING_EN
        .i_bright(bright_b),
`endif
        .o_fndSel(sel_b), .o_fndSelect(select_b), .o_blank(blank_b), .o_scanTick(tick_b)
    );

    fnd_digit_scanner #(.NUM_DIGITS(3), .SCAN_DIV(2), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_c (
        .i_clk(clk), .i_reset(rst_c), .i_enable(en_c), .i_digitMask(mask_c),
`ifdef FND_DIMMING_EN
        .i_bright(4'hF),
`endif
        .o_fndSel(sel_c), .o_fndSelect(select_c), .o_blank(blank_c), .o_scanTick(tick_c)
    );

    typedef struct {
        int         cyc;
        int         dut;
        logic [1:0] sel;
        logic [3:0] sel_oh;
        logic       blank;
        logic       tick;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_out(input int dut, input logic [1:0] sel, input logic [3:0] sel_oh,
                              input logic blank, input logic tick);
        exp_t e;
        e.cyc    = cyc_no;
        e.dut    = dut;
        e.sel    = sel;
        e.sel_oh = sel_oh;
        e.blank  = blank;
        e.tick   = tick;
        scb.push_back(e);
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // One 4-cycle slot of DUT A: blank cycle, then pat for three cycles, tick on the last.
    task automatic slot_a(input logic [1:0] idx, input logic [3:0] pat);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) expect_out(0, idx, 4'b0000, 1'b1, 1'b0);
            else        expect_out(0, idx, pat, (pat == 4'b0000), (c == 3));
            tick_clk();
        end
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    exp_t       m_e;
    logic [1:0] m_sel;
    logic [3:0] m_oh;
    logic       m_blank, m_tick;
    initial begin
        forever begin
            @(negedge clk);
            while (scb.size() > 0 && scb[0].cyc <= cyc_no) begin
                m_e = scb.pop_front();
                case (m_e.dut)
                    0:       begin m_sel = sel_a; m_oh = select_a;         m_blank = blank_a; m_tick = tick_a; end
                    1:       begin m_sel = sel_b; m_oh = select_b;         m_blank = blank_b; m_tick = tick_b; end
                    default: begin m_sel = sel_c; m_oh = {1'b0, select_c}; m_blank = blank_c; m_tick = tick_c; end
                endcase
                n_checks++;
                if (m_sel === m_e.sel && m_oh === m_e.sel_oh && m_blank === m_e.blank && m_tick === m_e.tick)
                    n_pass++;
                else
                    $display("FAIL dut%0d cyc%0d: got sel=%0d select=%b blank=%b tick=%b, expected sel=%0d select=%b blank=%b tick=%b",
                             m_e.dut, m_e.cyc, m_sel, m_oh, m_blank, m_tick,
                             m_e.sel, m_e.sel_oh, m_e.blank, m_e.tick);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0] mask;
        logic [1:0] sel;
        logic [2:0] oh;
        logic       blank;
        logic       tick;
    } vec_c_t;

    // Mask is applied during the row's cycle and affects the following rows.
    vec_c_t vec_c[16] = '{
        '{3'b111, 2'd0, 3'b000, 1'b1, 1'b0},
        '{3'b111, 2'd0, 3'b001, 1'b0, 1'b1},
        '{3'b111, 2'd1, 3'b010, 1'b0, 1'b0},
        '{3'b111, 2'd1, 3'b010, 1'b0, 1'b1},
        '{3'b111, 2'd2, 3'b100, 1'b0, 1'b0},
        '{3'b111, 2'd2, 3'b100, 1'b0, 1'b1},
        '{3'b111, 2'd0, 3'b001, 1'b0, 1'b0},
        '{3'b101, 2'd0, 3'b001, 1'b0, 1'b1},
        '{3'b101, 2'd2, 3'b100, 1'b0, 1'b0},
        '{3'b101, 2'd2, 3'b100, 1'b0, 1'b1},
        '{3'b001, 2'd0, 3'b001, 1'b0, 1'b0},
        '{3'b001, 2'd0, 3'b001, 1'b0, 1'b1},
        '{3'b010, 2'd0, 3'b001, 1'b0, 1'b0},
        '{3'b010, 2'd0, 3'b000, 1'b1, 1'b1},
        '{3'b010, 2'd1, 3'b010, 1'b0, 1'b0},
        '{3'b010, 2'd1, 3'b010, 1'b0, 1'b1}
    };

    logic [3:0] pat_b[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef FND_DIMMING_EN
    int lit_b[4] = '{16, 16, 32, 0};
`else
    int lit_b[4] = '{32, 32, 32, 32};
`endif

    initial begin
        rst_a = 1'b1; en_a = 1'b1; mask_a = 4'b1111;
        rst_b = 1'b1; en_b = 1'b1; mask_b = 4'b1111;
        rst_c = 1'b1; en_c = 1'b1; mask_c = 3'b111;
`ifdef FND_DIMMING_EN
        bright_b = 4'd8;
`endif
        tick_clk();

        repeat (2) begin
            expect_out(0, 2'd0, 4'b0000, 1'b1, 1'b0);
            expect_out(1, 2'd0, 4'b1111, 1'b1, 1'b0);
            expect_out(2, 2'd0, 4'b0000, 1'b1, 1'b0);
            tick_clk();
        end

        // Full mask: 0,1,2,3,0
        rst_a = 1'b0;
        slot_a(2'd0, 4'b0001); slot_a(2'd1, 4'b0010); slot_a(2'd2, 4'b0100);
        slot_a(2'd3, 4'b1000); slot_a(2'd0, 4'b0001);

        // Mask 0101 from the start of slot 1: current digit dark, then 2,0,2,0
        mask_a = 4'b0101;
        slot_a(2'd1, 4'b0000); slot_a(2'd2, 4'b0100); slot_a(2'd0, 4'b0001);
        slot_a(2'd2, 4'b0100); slot_a(2'd0, 4'b0001);

        // All-zero mask: index held, ticks continue, selects dark
        mask_a = 4'b0000;
        slot_a(2'd2, 4'b0000); slot_a(2'd2, 4'b0000); slot_a(2'd2, 4'b0000);

        // Only digit 3: reached at the next advance, then held
        mask_a = 4'b1000;
        slot_a(2'd2, 4'b0000); slot_a(2'd3, 4'b1000); slot_a(2'd3, 4'b1000);

        mask_a = 4'b1111;
        slot_a(2'd3, 4'b1000); slot_a(2'd0, 4'b0001); slot_a(2'd1, 4'b0010);

        // Enable low at counter=2 for 10 cycles, then one remaining cycle and the advance
        expect_out(0, 2'd2, 4'b0000, 1'b1, 1'b0); tick_clk();
        expect_out(0, 2'd2, 4'b0100, 1'b0, 1'b0); tick_clk();
        expect_out(0, 2'd2, 4'b0100, 1'b0, 1'b0);
        en_a = 1'b0;
        tick_clk();
        for (int i = 0; i < 10; i++) begin
            expect_out(0, 2'd2, 4'b0000, 1'b1, 1'b0);
            if (i == 9) en_a = 1'b1;
            tick_clk();
        end
        expect_out(0, 2'd2, 4'b0100, 1'b0, 1'b1); tick_clk();
        slot_a(2'd3, 4'b1000); slot_a(2'd0, 4'b0001); slot_a(2'd1, 4'b0010);

        // Asynchronous reset mid-slot at index 2, then the scan restarts at digit 0
        expect_out(0, 2'd2, 4'b0000, 1'b1, 1'b0); tick_clk();
        expect_out(0, 2'd2, 4'b0100, 1'b0, 1'b0); tick_clk();
        rst_a = 1'b1;
        expect_out(0, 2'd0, 4'b0000, 1'b1, 1'b0); tick_clk();
        rst_a = 1'b0;
        slot_a(2'd0, 4'b0001); slot_a(2'd1, 4'b0010);

        // DUT B: active-low polarity, 4-cycle blank window, optional dimming
        rst_b = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 36; c++) begin
                if (c >= 4 && c < 4 + lit_b[s])
                    expect_out(1, 2'(s), pat_b[s], 1'b0, (c == 35));
                else
                    expect_out(1, 2'(s), 4'b1111, 1'b1, (c == 35));
`ifdef FND_DIMMING_EN
                if (c == 10 && s == 1) bright_b = 4'd15;
                if (c == 10 && s == 2) bright_b = 4'd0;
`endif
                tick_clk();
            end
        end

        // DUT C: no blank gap, 3-digit wrap, skip and mid-slot masking
        rst_c = 1'b0;
        for (int r = 0; r < 16; r++) begin
            expect_out(2, vec_c[r].sel, {1'b0, vec_c[r].oh}, vec_c[r].blank, vec_c[r].tick);
            mask_c = vec_c[r].mask;
            tick_clk();
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (scb.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: %0d entries left, expected 0", scb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fnd_digit_scanner.md
Name: fnd_digit_scanner

Overview:
- Parametrised time-multiplexed digit scanner for the FND display path.
- Replaces the fixed 2-to-4 select decoder. Generates the scan index and one-hot digit select for NUM_DIGITS digits.
- Adds a built-in scan-rate prescaler, per-digit enable mask with skip, anti-ghosting blank window and selectable output polarity.
- Sits between the system clock domain and the segment mux; the segment mux consumes o_fndSel.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, 2..16.
- SEL_W, $clog2(NUM_DIGITS): width of the scan index.
- SCAN_DIV, 100000: clock cycles per digit slot, at least 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all selects inactive. Must be 0 ≤ BLANK_CYCLES < SCAN_DIV.
- ACTIVE_LOW, 0: 1 means the active select level is 0, so the inactive pattern is all ones.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_enable  input  1  scan run enable.
- i_digitMask  input  NUM_DIGITS  bit k=1 means digit k participates in the scan.
- o_fndSel  output  SEL_W  current digit index, to the segment data mux.
- o_fndSelect  output  NUM_DIGITS  one-hot digit select, polarity per ACTIVE_LOW.
- o_blank  output  1  high while all selects are inactive.
- o_scanTick  output  1  one-cycle pulse on each slot advance.

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-high on i_reset.
- All outputs are driven directly from flops or from a decode of registered state only. No combinational path from inputs to o_fndSelect, so selects are glitch-free.
- Reset values:
  - slot counter = 0, index = 0
  - o_fndSel = 0
  - o_fndSelect = inactive pattern
  - o_blank = 1, o_scanTick = 0
- Reset asserted mid-slot aborts the slot immediately to the reset values.
- Slot counter: counts 0..SCAN_DIV-1 while i_enable=1. At SCAN_DIV-1 it wraps to 0 on the next edge (terminal count).
- Advance rule at terminal count:
  - Search from index+1 upward, cyclically wrapping NUM_DIGITS-1 to 0, for the first index with mask bit 1; load it.
  - If no other bit is set but the current one is, keep the index.
  - If the mask is all zero, keep the index.
  - o_scanTick=1 for exactly the cycle in which the counter holds SCAN_DIV-1.
- Select gating: in a cycle with counter value c and index n, digit n is active iff all of:
  - c ≥ BLANK_CYCLES
  - i_digitMask[n]=1 (sampled into a register each cycle, so one cycle of latency)
  - i_enable=1
  - All other digits are inactive.
- o_blank = 1 whenever o_fndSelect equals the inactive pattern.
- Mask change mid-slot:
  - A masked current digit is blanked within 1 cycle.
  - The index change takes effect only at the next advance.
- i_enable=0: counter and index freeze, selects go inactive within 1 cycle, o_scanTick=0. On re-enable the count resumes from the frozen value.
- All-zero mask: counter keeps running, o_scanTick still pulses, selects stay inactive, o_blank=1.
- BLANK_CYCLES=0: the selected digit is active for the full slot, with no inactive gap between digits.

Optional Feature:
- Macro: FND_DIMMING_EN.
- When defined:
  - Adds input i_bright [3:0].
  - STEP = (SCAN_DIV-BLANK_CYCLES)/16, integer division.
  - In addition to the normal gating, the select is active only while (c - BLANK_CYCLES) < i_bright*STEP.
  - i_bright=15 means full post-blank slot, matching the non-dimmed behaviour. i_bright=0 means the display is dark, with o_blank=1.
  - i_bright is registered and takes effect at the next slot start only.
- When not defined: no i_bright port and no dimming logic; behaviour is exactly as in Behaviour.

Test Plan:
- Reset, default mask 4'b1111, SCAN_DIV=4, BLANK_CYCLES=1, i_enable=1:
  - Each 4-cycle slot gives o_fndSelect 0000 for 1 cycle, then the active pattern (0001 in slot 0, 0010 in slot 1, ...) for 3 cycles.
  - o_fndSel sequence 0,1,2,3,0.
  - o_scanTick on every 4th cycle.
- Mask 4'b0101: o_fndSel sequence 0,2,0,2; o_fndSelect never 0010 or 1000.
- Mask 4'b0000: o_fndSelect stays 0000, o_blank=1, o_scanTick still every 4 cycles. Then set mask 4'b1000: digit 3 is selected after the next advance.
- i_enable low at counter=2 for 10 cycles:
  - Selects go 0000 within 1 cycle; o_fndSel is held.
  - On re-enable, 1 remaining cycle, then the advance.
- i_reset pulsed mid-slot with index=2: the immediate asynchronous clear gives o_fndSel=0, o_fndSelect=0000, o_blank=1. The scan restarts at digit 0.
- ACTIVE_LOW=1, FND_DIMMING_EN, SCAN_DIV=36, BLANK_CYCLES=4, i_bright=8:
  - STEP=2; active pattern is 1110.
  - Active for 16 cycles (c=4..19), then 1111 for 16 cycles, each slot.
